// File: rtl/rom_loader_pkg.sv
// Shared constants and FSM state type for the CORDIC coefficient table loader.
package rom_loader_pkg;

  localparam int unsigned BYTES  = 6;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned CSUM_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHK   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/rom_byte_packer.sv
// MSB-first byte shift register with a byte counter; the first byte shifted
// in ends up in the top byte of the word.
module rom_byte_packer #(
  parameter int unsigned DATA_W = 48,
  parameter int unsigned BYTES  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic [2:0]        cnt_o,
  output logic              full_o
);

  logic [DATA_W-1:0] word_q, word_d;
  logic [2:0]        cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (shift_i) begin
      word_d = {word_q[DATA_W-9:0], byte_i};
      cnt_d  = cnt_q + 3'd1;
    end
    if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = word_q;
  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == 3'(BYTES));

endmodule

// File: rtl/rom_table_loader.sv
// Byte-stream front end for the 64x48 CORDIC coefficient table: packs bytes
// into entries, drives the table write port, then verifies a 16-bit checksum.
module rom_table_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 48,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = rom_loader_pkg::DEPTH,
  parameter int unsigned BYTES  = rom_loader_pkg::BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              cen,
  output logic              wen,
  output logic [ADDR_W-1:0] index_wri,
  output logic [DATA_W-1:0] D,
  output logic              busy,
  output logic              done,
  output logic              csum_err
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CSUM_W-1:0]   acc_q, acc_d;
  logic                can_take, xfer;
  logic                pk_clr, pk_shift;
  logic [DATA_W-1:0]   pk_word;
  logic [2:0]          pk_cnt;
  logic                pk_full;

  // The packer is reused in CHK to collect the two reference bytes: its
  // counter is cleared in WRITE, so word[15:0] holds {ref_hi, ref_lo} in DONE.
  rom_byte_packer #(
    .DATA_W (DATA_W),
    .BYTES  (BYTES)
  ) u_packer (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (pk_clr),
    .shift_i (pk_shift),
    .byte_i  (byte_in),
    .word_o  (pk_word),
    .cnt_o   (pk_cnt),
    .full_o  (pk_full)
  );

  // Abort withdraws ready so a same-cycle byte stays with the sender.
  assign can_take   = ((state_q == ST_LOAD) || (state_q == ST_CHK)) && !abort;
  assign xfer       = can_take && byte_valid;
  assign byte_ready = can_take;
  assign index_wri  = addr_q;
  assign D          = pk_word;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    acc_d    = acc_q;
    pk_clr   = 1'b0;
    pk_shift = 1'b0;
    cen      = 1'b1;
    wen      = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    csum_err = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) begin
          done     = 1'b1;
          csum_err = (pk_word[CSUM_W-1:0] != acc_q);
        end
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          acc_d   = '0;
          pk_clr  = 1'b1;
        end
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (xfer) begin
          pk_shift = 1'b1;
          acc_d    = acc_q + CSUM_W'(byte_in);
          if (pk_cnt == 3'(BYTES - 1)) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        busy   = 1'b1;
        pk_clr = 1'b1;
        if (pk_full) begin
          cen = 1'b0;
          wen = 1'b0;
        end
        if (addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_CHK;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_CHK: begin
        busy = 1'b1;
        if (xfer) begin
          pk_shift = 1'b1;
          if (pk_cnt == 3'd1) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d  = ST_IDLE;
      addr_d   = '0;
      acc_d    = '0;
      pk_clr   = 1'b1;
      pk_shift = 1'b0;
      cen      = 1'b1;
      wen      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
    end
  end

endmodule
